// File: rtl/ws2812_rainbow_source.sv
// Colour-wheel pixel source for the WS2812 serializer. It paces frames on a free-running
// timer and streams LED_COUNT brightness-scaled GRB words over a valid/ready handshake.
module ws2812_rainbow_source #(
    parameter int LED_COUNT    = 8,
    parameter int FRAME_PERIOD = 2700000,
    parameter int HUE_STEP     = 4,
    parameter int HUE_SPEED    = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [7:0]  brightness_i,
    output logic [23:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        pix_last_o,
    output logic        busy_o,
    output logic        frame_overrun_o
);
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, CALC, PRESENT} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          tick_pending_q;
    logic [7:0]    bright_q;
    logic [8:0]    led_idx_q;
    logic [7:0]    pix_hue_q;
    logic [7:0]    hue_base_q;
    logic [23:0]   pix_data_q;
    logic          pix_valid_q;
    logic          pix_last_q;
    logic          busy_q;
    logic          frame_overrun_q;

    logic          wrap;
    logic [9:0]    hue10, k10, up10, dn10;
    logic [7:0]    r8, g8, b8;
    logic [8:0]    bmul;
    logic [23:0]   pix_data_d;
    logic          pix_last_d;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [8:0] m);
        logic [15:0] p;
        p = {8'b0, c} * {7'b0, m};
        return p[15:8];
    endfunction

    assign wrap = (timer_q == TW'(FRAME_PERIOD - 1));
    assign bmul = {1'b0, bright_q} + 9'd1;

    // Three 85-step segments of the wheel; 3*k never exceeds 255 so nothing saturates.
    always_comb begin
        hue10 = {2'b00, pix_hue_q};
        k10   = 10'd0;
        r8    = 8'd0;
        g8    = 8'd0;
        b8    = 8'd0;
        if (hue10 < 10'd85)       k10 = hue10;
        else if (hue10 < 10'd170) k10 = hue10 - 10'd85;
        else                      k10 = hue10 - 10'd170;
        up10 = 10'd3 * k10;
        dn10 = 10'd255 - up10;
        if (hue10 < 10'd85) begin
            r8 = dn10[7:0];
            g8 = up10[7:0];
        end else if (hue10 < 10'd170) begin
            g8 = dn10[7:0];
            b8 = up10[7:0];
        end else begin
            r8 = up10[7:0];
            b8 = dn10[7:0];
        end
        pix_data_d = {scale(g8, bmul), scale(r8, bmul), scale(b8, bmul)};
        pix_last_d = (led_idx_q == 9'(LED_COUNT - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            tick_pending_q  <= 1'b1;
            bright_q        <= 8'd0;
            led_idx_q       <= 9'd0;
            pix_hue_q       <= 8'd0;
            hue_base_q      <= 8'd0;
            pix_data_q      <= 24'd0;
            pix_valid_q     <= 1'b0;
            pix_last_q      <= 1'b0;
            busy_q          <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            frame_overrun_q <= 1'b0;
            timer_q         <= wrap ? '0 : timer_q + TW'(1);
            case (state_q)
                IDLE: begin
                    if (tick_pending_q && enable_i) begin
                        tick_pending_q <= 1'b0;
                        bright_q       <= brightness_i;
                        led_idx_q      <= 9'd0;
                        pix_hue_q      <= hue_base_q;
                        busy_q         <= 1'b1;
                        state_q        <= CALC;
                    end
                end
                CALC: begin
                    pix_data_q  <= pix_data_d;
                    pix_last_q  <= pix_last_d;
                    pix_valid_q <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (pix_ready_i) begin
                        pix_valid_q <= 1'b0;
                        if (pix_last_q) begin
                            hue_base_q <= hue_base_q + 8'(HUE_SPEED);
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            led_idx_q <= led_idx_q + 9'd1;
                            pix_hue_q <= pix_hue_q + 8'(HUE_STEP);
                            state_q   <= CALC;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A wrap overrides the start-of-frame clear so a tick is never lost.
            if (wrap) begin
                tick_pending_q <= 1'b1;
                if (state_q != IDLE) frame_overrun_q <= 1'b1;
            end
        end
    end

    assign pix_data_o      = pix_data_q;
    assign pix_valid_o     = pix_valid_q;
    assign pix_last_o      = pix_last_q;
    assign busy_o          = busy_q;
    assign frame_overrun_o = frame_overrun_q;
endmodule
